// File: rtl/branch_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, BTB entry
// layout and the update command carried from the resolve stage to the table.
package branch_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_e;

  localparam ctr_e CTR_RST = WEAK_NT;

  // Tag is held zero-extended to 32 bits so the struct is independent of PC_W.
  typedef struct packed {
    logic        valid;
    ctr_e        ctr;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  localparam btb_entry_t BTB_RST = '{valid: 1'b0, ctr: CTR_RST, tag: 32'd0, target: 32'd0};

  typedef struct packed {
    logic        en;
    logic        inval;
    logic        taken;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_upd_t;

  function automatic ctr_e ctr_step(ctr_e c, logic taken);
    ctr_e n;
    n = c;
    if (taken && c != STRONG_T)       n = ctr_e'(c + 2'd1);
    else if (!taken && c != STRONG_NT) n = ctr_e'(c - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/branch_target_table.sv
// Predictor/BTB storage: one async read port for fetch and one sync
// read-modify-write update port; synchronous active-low clear.
module branch_target_table
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output btb_entry_t       rd_entry_o,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  btb_upd_t         upd_i
);

  btb_entry_t mem_q [DEPTH];
  btb_entry_t cur;
  btb_entry_t upd_d;
  logic       hit;

  assign rd_entry_o = mem_q[rd_idx_i];

  // A miss reloads the counter to the weak state of the outcome instead of stepping.
  always_comb begin
    cur   = mem_q[upd_idx_i];
    hit   = cur.valid && (cur.tag == upd_i.tag);
    upd_d = cur;
    if (upd_i.inval) begin
      upd_d.valid = 1'b0;
    end else begin
      upd_d.ctr = hit ? ctr_step(cur.ctr, upd_i.taken) : (upd_i.taken ? WEAK_T : WEAK_NT);
      if (upd_i.taken) begin
        upd_d.valid  = 1'b1;
        upd_d.tag    = upd_i.tag;
        upd_d.target = upd_i.target;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= BTB_RST;
    end else if (upd_i.en) begin
      mem_q[upd_idx_i] <= upd_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: combinational BTB lookup at fetch, resolve/mispredict logic
// at execute. Define BRANCH_PERF_CNT_EN to add the perf_* counter outputs.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic            ex_branch,
  input  logic            ex_jalr,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic [31:0]     pc_four,
  output logic [31:0]     br_pc,
  output logic            mispredict,
  output logic [31:0]     redirect_pc
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  btb_entry_t       rd;
  btb_upd_t         upd;
  logic [IDX_W-1:0] f_idx, ex_idx;
  logic [31:0]      f_tag, ex_tag, ex_pc32;
  logic             taken;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^{if_pc[1:0], ex_pc[1:0]};

  assign f_idx  = if_pc[IDX_W+1:2];
  assign f_tag  = 32'(if_pc[PC_W-1:IDX_W+2]);
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = 32'(ex_pc[PC_W-1:IDX_W+2]);

  assign pred_taken  = rd.valid && (rd.tag == f_tag) && (rd.ctr == WEAK_T || rd.ctr == STRONG_T);
  assign pred_target = pred_taken ? rd.target : 32'd0;

  assign ex_pc32     = 32'(ex_pc);
  assign pc_four     = ex_pc32 + 32'd4;
  assign br_pc       = ex_pc32 + (ex_jalr ? ex_alu_result : ex_imm);
  assign taken       = ex_branch && (ex_alu_result[0] || ex_jalr);
  assign mispredict  = ex_valid && ((taken != ex_pred_taken) || (taken && br_pc != ex_pred_target));
  assign redirect_pc = taken ? br_pc : pc_four;

  // A predicted-taken non-branch is an alias: drop the entry instead of training it.
  assign upd = '{en:     ex_valid && (ex_branch || ex_pred_taken),
                 inval:  !ex_branch,
                 taken:  taken,
                 tag:    ex_tag,
                 target: br_pc};

  branch_target_table #(.DEPTH(BHT_DEPTH)) u_btb (
    .clk_i      (clk),
    .rst_ni     (reset),
    .rd_idx_i   (f_idx),
    .rd_entry_o (rd),
    .upd_idx_i  (ex_idx),
    .upd_i      (upd)
  );

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  assign br_cnt_d  = br_cnt_q + 32'((ex_valid && ex_branch) ? 1 : 0);
  assign mis_cnt_d = mis_cnt_q + 32'(mispredict ? 1 : 0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign perf_branches    = br_cnt_q;
  assign perf_mispredicts = mis_cnt_q;
`endif

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning program-counter width in bits; PC is zero-extended to 32 bits internally.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, meaning number of predictor/BTB entries; power of two, and PC_W > log2(BHT_DEPTH)+2.
REQ-003 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous active-low reset (one clock; reset is synchronous and active-low).
REQ-004 SHALL have fetch ports: if_pc input PC_W, fetch PC; pred_taken output 1, predicted taken; pred_target output 32, predicted target.
REQ-005 SHALL have resolve ports: ex_valid in 1; ex_pc in PC_W; ex_imm in 32; ex_branch in 1; ex_jalr in 1; ex_alu_result in 32; ex_pred_taken in 1; ex_pred_target in 32.
REQ-006 SHALL have resolve outputs: pc_four out 32, ex_pc+4; br_pc out 32, resolved target; mispredict out 1, flush request; redirect_pc out 32, correct next PC.

Function
REQ-007 Index SHALL be pc[IDX_W+1:2] and tag pc[PC_W-1:IDX_W+2], where IDX_W=log2(BHT_DEPTH).
REQ-008 Each entry SHALL hold a 2-bit saturating counter, valid bit, tag, and 32-bit target.
REQ-009 Fetch lookup SHALL be combinational: pred_taken=1 only if valid, tag match, and counter MSB=1; pred_target=stored target when pred_taken=1, else 0.
REQ-010 Actual taken SHALL be ex_branch && (ex_alu_result[0] || ex_jalr).
REQ-011 br_pc SHALL be ex_pc+ex_alu_result when ex_jalr=1, otherwise ex_pc+ex_imm; additions are modulo 2^32.
REQ-012 mispredict SHALL be ex_valid && (taken != ex_pred_taken || (taken && br_pc != ex_pred_target)), combinationally.
REQ-013 redirect_pc SHALL be br_pc if taken, otherwise pc_four.
REQ-014 On clk when ex_valid && ex_branch: counter SHALL increment if taken, else decrement, saturating at 3/0; a tag miss SHALL first reload the counter to 2 (taken) or 1 (not taken).
REQ-015 On same update, if taken: valid<=1, tag and target<=br_pc; if not taken, target and valid unchanged.
REQ-016 When ex_valid && !ex_branch && ex_pred_taken (alias), the indexed entry's valid SHALL clear; mispredict=1 and redirect_pc=pc_four.
REQ-017 When ex_valid=0, no state SHALL change and mispredict SHALL be 0.
REQ-018 Simultaneous fetch and update of one index: fetch SHALL see pre-update contents; new value visible next cycle.

Reset
REQ-019 While reset=0 at clk: all valid bits 0, all counters 1 (weakly not-taken), tags/targets 0, perf counters 0.
REQ-020 Reset SHALL take precedence over a concurrent update; combinational outputs follow inputs and cleared state (pred_taken=0, pred_target=0).

Configuration
REQ-021 Macro BRANCH_PERF_CNT_EN defined: SHALL add outputs perf_branches (32, count of ex_valid&&ex_branch) and perf_mispredicts (32, count of mispredict=1 cycles), wrapping at 2^32.
REQ-022 Macro undefined: SHALL omit those ports and counters, with all other behaviour identical.

Structure
REQ-023 Package branch_pkg SHALL hold the counter enum (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3), the BTB entry struct, and counter reset value.
REQ-024 Storage SHALL be sub-module branch_target_table (one async read port, one sync write port, sync active-low clear); branch_predict_unit holds resolve logic and perf counters.

Verification
REQ-025 Reset, then if_pc=0x010 -> pred_taken=0, pred_target=0.
REQ-026 ex_pc=0x010, ex_branch=1, alu_result=1, imm=0x20, pred_taken=0 -> br_pc=0x30, mispredict=1, redirect_pc=0x30; next cycle if_pc=0x010 -> pred_taken=1, pred_target=0x30.
REQ-027 Same branch resolved not-taken twice from counter 2 -> counter 1, then 0; pred_taken=0; mispredict=1 on first resolve (pred_taken=1), 0 on second.
REQ-028 ex_jalr=1, ex_pc=0x040, alu_result=0x100, pred_taken=0 -> br_pc=0x140, mispredict=1; predicted taken with target 0x140 -> mispredict=0.
REQ-029 Index 4 written at PC 0x010 with tag 0; fetch 0x050 (index 4, tag 1) -> pred_taken=0; alias resolve at 0x010 with ex_branch=0, pred_taken=1 -> mispredict=1, redirect 0x014, valid cleared.
REQ-030 With BRANCH_PERF_CNT_EN: 5 branches, 2 mispredicted -> perf_branches=5, perf_mispredicts=2; reset mid-run -> both 0.
